// File: rtl/tc_shared_mult_arbiter_if.sv
// Handshake and result bus of the shared multiplier arbiter.
//   ce        : clock enable; 0 freezes arbiter and pipeline
//   req_valid : per-requester operand-pending flags
//   req_ready : one-hot grant; accept = req_valid[i] & req_ready[i]
//   req_a/b   : packed signed operands, slice i = [i*W +: W]
//   rsp_valid : result valid (no backpressure)
//   rsp_id    : requester index of the result
//   rsp_p     : signed product, low P_W bits
//   busy      : any operation in flight
// slave is the arbiter side, master is the requester/consumer side.
interface tc_shared_mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = 18,
  parameter int unsigned B_W     = 18,
  parameter int unsigned P_W     = 33,
  parameter int unsigned ID_W    = 2
);
  logic                   ce;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_p;
  logic                   busy;

  modport slave (
    input  ce, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output ce, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/tc_shared_mult_arbiter.sv
// Shares one signed A_W x B_W multiplier among NUM_REQ requesters.
// Round-robin grant, fully pipelined (one op per cycle), each result tagged with the
// index of the requester that issued it. Results appear LATENCY cycles after accept.
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : asynchronous active-high reset
//   bus    : tc_shared_mult_arbiter_if.slave (ce, request handshake, result, busy)
module tc_shared_mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = 18,
  parameter int unsigned B_W     = 18,
  parameter int unsigned P_W     = 33,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  tc_shared_mult_arbiter_if.slave bus
);

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic               w_accept;
  logic [A_W-1:0]     w_a;
  logic [B_W-1:0]     w_b;

  logic [LATENCY-1:0] r_vld;
  logic [ID_W-1:0]    r_id [LATENCY];
  logic [P_W-1:0]     w_rsp_p;

  // Round-robin search starting at r_ptr; first pending requester wins.
  always_comb begin : arb
    logic [ID_W:0] sum;
    sum     = '0;
    w_any   = 1'b0;
    w_win   = '0;
    w_grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!w_any && bus.req_valid[sum[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = sum[ID_W-1:0];
      end
    end
    if (w_any) w_grant[w_win] = 1'b1;
  end

  assign w_ready  = (bus.ce && !ap_rst) ? w_grant : '0;
  assign w_accept = |(bus.req_valid & w_ready);

  assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);

  // Winner operand mux.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_win == ID_W'(k)) begin
        w_a = bus.req_a[k*A_W +: A_W];
        w_b = bus.req_b[k*B_W +: B_W];
      end
    end
  end

  // Pointer, valid and id pipeline. Id registers load only behind a valid so bubbles
  // leave the previous result id on the output.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_ptr <= '0;
      r_vld <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) r_id[k] <= '0;
    end else if (bus.ce) begin
      if (w_accept) begin
        r_ptr   <= w_ptr_nxt;
        r_id[0] <= w_win;
      end
      r_vld[0] <= w_accept;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_id[k] <= r_id[k-1];
      end
    end
  end

  // Operands are sign-extended to P_W before multiplying: the low P_W bits of the
  // extended product equal the low P_W bits of the full signed product.
  if (LATENCY == 1) begin : g_lat1
    logic [P_W-1:0] w_ax;
    logic [P_W-1:0] w_bx;
    logic [P_W-1:0] w_prod;
    logic [P_W-1:0] r_p;

    assign w_ax   = {{(P_W-A_W){w_a[A_W-1]}}, w_a};
    assign w_bx   = {{(P_W-B_W){w_b[B_W-1]}}, w_b};
    assign w_prod = w_ax * w_bx;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        r_p <= '0;
      end else if (bus.ce && w_accept) begin
        r_p <= w_prod;
      end
    end

    assign w_rsp_p = r_p;
  end else begin : g_latn
    logic [A_W-1:0] r_a;
    logic [B_W-1:0] r_b;
    logic [P_W-1:0] w_ax;
    logic [P_W-1:0] w_bx;
    logic [P_W-1:0] w_prod;
    logic [P_W-1:0] r_p [LATENCY-1];

    assign w_ax   = {{(P_W-A_W){r_a[A_W-1]}}, r_a};
    assign w_bx   = {{(P_W-B_W){r_b[B_W-1]}}, r_b};
    assign w_prod = w_ax * w_bx;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        r_a <= '0;
        r_b <= '0;
        for (int unsigned k = 0; k < LATENCY - 1; k++) r_p[k] <= '0;
      end else if (bus.ce) begin
        if (w_accept) begin
          r_a <= w_a;
          r_b <= w_b;
        end
        if (r_vld[0]) r_p[0] <= w_prod;
        for (int unsigned k = 1; k < LATENCY - 1; k++) begin
          if (r_vld[k]) r_p[k] <= r_p[k-1];
        end
      end
    end

    assign w_rsp_p = r_p[LATENCY-2];
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_vld[LATENCY-1];
  assign bus.rsp_id    = r_id[LATENCY-1];
  assign bus.rsp_p     = w_rsp_p;
  assign bus.busy      = |r_vld;

endmodule

// File: tb/tb_tc_shared_mult_arbiter.sv
module tb_tc_shared_mult_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  tc_shared_mult_arbiter_if #(.NUM_REQ(4), .A_W(18), .B_W(18), .P_W(33), .ID_W(2)) bus ();

  tc_shared_mult_arbiter #(
    .NUM_REQ(4), .A_W(18), .B_W(18), .P_W(33), .LATENCY(LAT), .ID_W(2)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ptr, FIFO of issued ops with due times counted in enabled edges.
  typedef struct {
    int          id;
    logic [32:0] p;
    int          due;
  } op_t;
  op_t         q[$];
  int          m_ptr;
  int          m_t;
  logic        m_vld;
  logic [1:0]  m_id;
  logic [32:0] m_p;

  logic [17:0] ta[N];
  logic [17:0] tb[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_prod(input logic [17:0] a, input logic [17:0] b);
    longint pa;
    longint pb;
    logic [63:0] t;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    t  = 64'(pa * pb);
    return t[32:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    m_t   = 0;
    m_vld = 1'b0;
    m_id  = '0;
    m_p   = '0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(m_vld));
    chk({tag, ".rsp_id"}, 64'(bus.rsp_id), 64'(m_id));
    chk({tag, ".rsp_p"}, 64'(bus.rsp_p), 64'(m_p));
    chk({tag, ".busy"}, 64'(bus.busy), 64'((q.size() > 0) || m_vld));
  endtask

  // One clock cycle: drive, check grant, clock, check outputs against the model.
  task automatic step(input logic [3:0] v, input logic c, output logic [3:0] obs_rdy);
    int g;
    logic [3:0] exp_rdy;
    op_t op;
    bus.req_valid = v;
    bus.ce        = c;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*18 +: 18] = ta[i];
      bus.req_b[i*18 +: 18] = tb[i];
    end
    #1;
    g = -1;
    if (c) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_rdy = bus.req_ready;
    chk("req_ready", 64'(obs_rdy), 64'(exp_rdy));
    if (g >= 0) begin
      op.id  = g;
      op.p   = ref_prod(ta[g], tb[g]);
      op.due = m_t + LAT;
      q.push_back(op);
      m_ptr = (g + 1) % N;
    end
    @(posedge ap_clk);
    #1;
    if (c) begin
      m_t++;
      m_vld = 1'b0;
      if (q.size() > 0 && q[0].due == m_t) begin
        m_vld = 1'b1;
        m_id  = 2'(q[0].id);
        m_p   = q[0].p;
        void'(q.pop_front());
      end
    end
    chk_outputs("cycle");
  endtask

  // Asynchronous reset asserted and released away from the clock edge.
  task automatic do_reset();
    bus.req_valid = 4'hF;
    bus.ce        = 1'b1;
    #3;
    ap_rst = 1'b1;
    #1;
    model_reset();
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst.rsp_p", 64'(bus.rsp_p), 64'(0));
    @(posedge ap_clk);
    #1;
    chk("rst_hold.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_hold.req_ready", 64'(bus.req_ready), 64'(0));
    #2;
    ap_rst = 1'b0;
  endtask

  task automatic rand_ops();
    logic [31:0] r;
    for (int i = 0; i < N; i++) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: ta[i] = 18'h20000;
        1: ta[i] = 18'h1FFFF;
        default: ta[i] = r[17:0];
      endcase
      r = $urandom();
      case ($urandom_range(0, 5))
        0: tb[i] = 18'h20000;
        1: tb[i] = 18'h1FFFF;
        default: tb[i] = r[31:14];
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rdy;
    logic [3:0] rv;
    logic [32:0] e_p;
    model_reset();
    bus.ce        = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0;
      tb[i] = '0;
    end
    #2;
    chk_outputs("reset");
    chk("reset.req_ready", 64'(bus.req_ready), 64'(0));
    #10;
    ap_rst = 1'b0;

    // Sparse: idle keeps ptr at 0; req 3 wraps ptr to 0; req 1 then moves it to 2.
    step(4'b0000, 1'b1, rdy);
    step(4'b0000, 1'b1, rdy);
    step(4'b1000, 1'b1, rdy);
    chk("sparse.req3", 64'(rdy), 64'(4'b1000));
    step(4'b0010, 1'b1, rdy);
    chk("sparse.req1", 64'(rdy), 64'(4'b0010));
    step(4'b1111, 1'b1, rdy);
    chk("sparse.ptr2", 64'(rdy), 64'(4'b0100));
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, rdy);

    // Single op from requester 2 (ptr is now 3, req 2 is still reached).
    ta[2] = 18'(-3);
    tb[2] = 18'd131071;
    step(4'b0100, 1'b1, rdy);
    chk("single.grant", 64'(rdy), 64'(4'b0100));
    step(4'b0000, 1'b1, rdy);
    e_p = -33'sd393213;
    chk("single.valid", 64'(bus.rsp_valid), 64'(1));
    chk("single.id", 64'(bus.rsp_id), 64'(2));
    chk("single.p", 64'(bus.rsp_p), 64'(e_p));
    step(4'b0000, 1'b1, rdy);
    chk("single.bubble_hold", 64'(bus.rsp_p), 64'(e_p));

    // Wrap/truncation corner products, back to back.
    ta[3] = 18'h20000;
    tb[3] = 18'h20000;
    ta[0] = 18'h1FFFF;
    tb[0] = 18'h1FFFF;
    step(4'b1001, 1'b1, rdy);
    step(4'b0001, 1'b1, rdy);
    chk("wrap.min_x_min", 64'(bus.rsp_p), 64'(0));
    step(4'b0000, 1'b1, rdy);
    chk("wrap.max_x_max", 64'(bus.rsp_p), 64'(33'h1FFFC0001));
    step(4'b0000, 1'b1, rdy);

    // ce freeze with two ops in flight.
    rand_ops();
    step(4'b0010, 1'b1, rdy);
    step(4'b0100, 1'b1, rdy);
    rv = {3'b000, bus.rsp_valid};
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, rdy);
      chk("ce.frozen_valid", 64'(bus.rsp_valid), 64'(rv));
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, rdy);

    // Reset mid-burst discards everything in flight.
    rand_ops();
    step(4'b1111, 1'b1, rdy);
    step(4'b1111, 1'b1, rdy);
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, rdy);

    // Fairness under full load from ptr 0.
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step(4'b1111, 1'b1, rdy);
      chk("fair.order", 64'(rdy), 64'(1 << (i % 4)));
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, rdy);

    // Randomized traffic with occasional ce drops and one reset.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      rv = 4'($urandom());
      step(rv, ($urandom_range(0, 7) != 0), rdy);
      if (i == 200) do_reset();
    end
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, rdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
